// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
package edge_det_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_e;

  // Width of a counter that must hold values 0..cycles.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, debounce filter, mode-gated event pulse and sticky status flag.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  input  edge_mode_e mode,
  input  logic       evt_clear,
  output logic       level,
  output logic       pulse,
  output logic       evt_status
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;
  logic                   update;
  logic                   want_edge;

  assign s         = sync_q[SYNC_STAGES-1];
  assign update    = (s != level) && (cnt_q == CNT_LAST);
  assign want_edge = (s & mode[0]) | (~s & mode[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level      <= 1'b0;
      pulse      <= 1'b0;
      evt_status <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      // Any return to the accepted level restarts the persistence count.
      if (s == level) begin
        cnt_q <= '0;
      end else if (update) begin
        level <= s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      pulse      <= update & want_edge;
      // A new pulse wins over a simultaneous clear so no event is lost.
      evt_status <= pulse | (evt_status & ~evt_clear);
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel filters plus a registered, masked interrupt request.
module multi_edge_detector
  import edge_det_pkg::*;
#(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   din,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   irq_en,
  input  logic [CHANNELS-1:0]   evt_clear,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   evt_status,
  output logic                  irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .din       (din[i]),
      .mode      (edge_mode_e'(mode[2*i +: 2])),
      .evt_clear (evt_clear[i]),
      .level     (level[i]),
      .pulse     (pulse[i]),
      .evt_status(evt_status[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= |(evt_status & irq_en);
  end

endmodule
